// File: rtl/cfg_disp_pkg.sv
// -----------------------------------------------------------------------------
// cfg_disp_pkg
// Shared definitions for the configuration readback display:
//   - conversion FSM state encoding
//   - active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
//   - display geometry and value width
//   - seg_decode(): BCD digit to segment pattern (non-decimal codes blank)
// -----------------------------------------------------------------------------
package cfg_disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int VAL_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/cfg_readback_display_if.sv
// -----------------------------------------------------------------------------
// cfg_readback_display_if
// Bundles the register-bank side (h_select, h0..h3) and the board display side
// (AN, SEG, DP) plus the converter busy flag.
//   master : register bank / board top  -> drives h_*, observes AN/SEG/DP/busy
//   slave  : cfg_readback_display        -> reads h_*, drives AN/SEG/DP/busy
// -----------------------------------------------------------------------------
interface cfg_readback_display_if;
  import cfg_disp_pkg::*;

  logic [1:0]       h_select;
  logic [VAL_W-1:0] h0;
  logic [VAL_W-1:0] h1;
  logic [VAL_W-1:0] h2;
  logic [2:0]       h3;
  logic [7:0]       AN;
  logic [6:0]       SEG;
  logic             DP;
  logic             busy;

  modport master (
    output h_select, h0, h1, h2, h3,
    input  AN, SEG, DP, busy
  );

  modport slave (
    input  h_select, h0, h1, h2, h3,
    output AN, SEG, DP, busy
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter for a VAL_W-bit binary value.
//   clk, rst : clock, asynchronous active-low reset
//   start    : accepted only in IDLE; captures bin
//   bin      : binary input
//   busy     : high from the capture edge until DONE is left
//   done     : high for the single DONE cycle; ones/tens valid then
//   ones     : BCD units digit
//   tens     : BCD tens digit
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import cfg_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens
);

  // Working register layout: {tens[3:0], ones[3:0], bin[VAL_W-1:0]}
  localparam int SR_W = 8 + VAL_W;

  conv_state_e     state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d, adj;
  logic [2:0]      cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == 3'(VAL_W - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Datapath: one correct-then-shift step per SHIFT cycle
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    adj   = sr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d  = {8'd0, bin};
          cnt_d = 3'd0;
        end
      end
      ST_SHIFT: begin
        if (adj[VAL_W+3:VAL_W] >= 4'd5)   adj[VAL_W+3:VAL_W]   = adj[VAL_W+3:VAL_W] + 4'd3;
        if (adj[VAL_W+7:VAL_W+4] >= 4'd5) adj[VAL_W+7:VAL_W+4] = adj[VAL_W+7:VAL_W+4] + 4'd3;
        sr_d  = {adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= 3'd0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ones = sr_q[VAL_W+3:VAL_W];
  assign tens = sr_q[VAL_W+7:VAL_W+4];

endmodule

// File: rtl/cfg_readback_display.sv
// -----------------------------------------------------------------------------
// cfg_readback_display
// Shows the selected configuration register in decimal on the Nexys A7
// seven-segment display: units on digit 0, tens on digit 1 (blank when zero),
// digit 2 blank, register index on digit 3. Digits 7..4 stay dark.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of cfg_readback_display_if (h_select, h0..h3 in;
//          AN, SEG, DP, busy out)
// REFRESH_DIV : clock cycles each digit stays lit (minimum 2)
// -----------------------------------------------------------------------------
module cfg_readback_display
  import cfg_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  cfg_readback_display_if.slave  bus
);

  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(REFRESH_DIV - 1);

  logic [VAL_W-1:0] sel_val;
  logic             trigger;
  logic             conv_busy, conv_done;
  logic [3:0]       conv_ones, conv_tens;

  logic [VAL_W-1:0] last_val_q;
  logic [1:0]       last_sel_q;
  logic             valid_q;
  logic [3:0]       ones_q, tens_q;
  logic [1:0]       idx_q;

  logic [RCNT_W-1:0] rcnt_q;
  logic [1:0]        digit_q;
  logic [7:0]        an_d, an_q;
  logic [6:0]        seg_d, seg_q;

  always_comb begin
    sel_val = '0;
    case (bus.h_select)
      2'd0:    sel_val = bus.h0;
      2'd1:    sel_val = bus.h1;
      2'd2:    sel_val = bus.h2;
      default: sel_val = {2'b00, bus.h3};
    endcase
  end

  // Converter busy doubles as "not in IDLE": changes during a conversion are
  // simply re-evaluated once it returns to IDLE.
  assign trigger = !conv_busy &&
                   (!valid_q || (sel_val != last_val_q) || (bus.h_select != last_sel_q));

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (trigger),
    .bin   (sel_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .ones  (conv_ones),
    .tens  (conv_tens)
  );

  // Capture bookkeeping and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_val_q <= '0;
      last_sel_q <= 2'd0;
      valid_q    <= 1'b0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      idx_q      <= 2'd0;
    end else begin
      if (trigger) begin
        last_val_q <= sel_val;
        last_sel_q <= bus.h_select;
      end
      if (conv_done) begin
        ones_q  <= conv_ones;
        tens_q  <= conv_tens;
        idx_q   <= last_sel_q;
        valid_q <= 1'b1;
      end
    end
  end

  // Refresh timebase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_q  <= '0;
      digit_q <= 2'd0;
    end else if (rcnt_q == RCNT_MAX) begin
      rcnt_q  <= '0;
      digit_q <= digit_q + 2'd1;
    end else begin
      rcnt_q  <= rcnt_q + 1'b1;
    end
  end

  // Anode decode: one low bit among the active digits, upper anodes dark
  for (genvar gi = 0; gi < 8; gi++) begin : g_an
    if (gi < NUM_DIGITS) begin : g_active
      assign an_d[gi] = (digit_q != 2'(gi));
    end else begin : g_dark
      assign an_d[gi] = 1'b1;
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    case (digit_q)
      2'd0:    seg_d = seg_decode(ones_q);
      2'd1:    seg_d = (tens_q == 4'd0) ? SEG_BLANK : seg_decode(tens_q);
      2'd2:    seg_d = SEG_BLANK;
      default: seg_d = seg_decode({2'b00, idx_q});
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.AN   = an_q;
  assign bus.SEG  = seg_q;
  assign bus.DP   = 1'b1;
  assign bus.busy = conv_busy;

endmodule

// File: tb/tb_cfg_readback_display.sv
module tb_cfg_readback_display;

  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cfg_readback_display_if bus ();

  cfg_readback_display #(.REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference segment table (active-low {g,f,e,d,c,b,a})
  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Model of what is currently on the display
  int m_sel = -1;
  int m_val = -1;

  logic [6:0] cap_seg [4];
  bit         cap_seen [4];

  function automatic logic [6:0] exp_seg(input int dig, input int val, input int sel);
    int ones;
    int tens;
    ones = val % 10;
    tens = val / 10;
    case (dig)
      0:       return seg_tbl[ones];
      1:       return (tens == 0) ? 7'h7F : seg_tbl[tens];
      3:       return seg_tbl[sel];
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy-high samples until busy falls (bounded)
  task automatic wait_conv(output int len);
    len = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.busy) len++;
      else if (len > 0) return;
    end
  endtask

  // Watches one full refresh round and records the segments seen per digit
  task automatic capture();
    logic [3:0] pat;
    for (int d = 0; d < 4; d++) cap_seen[d] = 1'b0;
    for (int i = 0; i < 4 * RD + 4; i++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        pat = 4'b0001 << d;
        if (bus.AN[3:0] == ~pat) begin
          cap_seg[d]  = bus.SEG;
          cap_seen[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_select(input int sel, input int val);
    bit expect_conv;
    int len;
    int hi;
    logic [6:0] e;
    expect_conv = (sel != m_sel) || (val != m_val);
    bus.h_select = 2'(sel);
    bus.h0 = (sel == 0) ? 5'(val) : 5'($urandom_range(0, 31));
    bus.h1 = (sel == 1) ? 5'(val) : 5'($urandom_range(0, 31));
    bus.h2 = (sel == 2) ? 5'(val) : 5'($urandom_range(0, 31));
    bus.h3 = (sel == 3) ? 3'(val) : 3'($urandom_range(0, 7));
    if (expect_conv) begin
      wait_conv(len);
      total++;
      if (len != 6) begin
        bad++;
        $display("FAIL conv_len sel=%0d val=%0d got=%0d want=6", sel, val, len);
      end
    end else begin
      hi = 0;
      repeat (12) begin
        tick();
        if (bus.busy) hi++;
      end
      total++;
      if (hi != 0) begin
        bad++;
        $display("FAIL no_retrigger sel=%0d val=%0d busy_cycles=%0d want=0", sel, val, hi);
      end
    end
    m_sel = sel;
    m_val = val;
    capture();
    for (int d = 0; d < 4; d++) begin
      e = exp_seg(d, val, sel);
      total++;
      if (!cap_seen[d] || cap_seg[d] !== e) begin
        bad++;
        $display("FAIL digit%0d sel=%0d val=%0d got=%b seen=%0d want=%b",
                 d, sel, val, cap_seg[d], cap_seen[d], e);
      end
    end
    $display("xfer sel=%0d val=%0d conv=%0d digits=%b/%b/%b/%b", sel, val, expect_conv,
             cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]);
  endtask

  task automatic test_reset();
    int len;
    bus.h_select = 2'd0;
    bus.h0 = 5'd17; bus.h1 = 5'd0; bus.h2 = 5'd0; bus.h3 = 3'd0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();                 // conversion of 17 is in flight
    #2 rst = 1'b0;                     // asynchronous assertion mid-cycle
    #1;
    total++;
    if (bus.AN !== 8'hFF || bus.SEG !== 7'h7F || bus.busy !== 1'b0 || bus.DP !== 1'b1) begin
      bad++;
      $display("FAIL reset_async AN=%h SEG=%h busy=%b DP=%b want AN=ff SEG=7f busy=0 DP=1",
               bus.AN, bus.SEG, bus.busy, bus.DP);
    end
    bus.h0 = 5'd0;
    tick();
    total++;
    if (bus.AN !== 8'hFF || bus.SEG !== 7'h7F || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_held AN=%h SEG=%h busy=%b", bus.AN, bus.SEG, bus.busy);
    end
    rst = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL first_edge_start busy=%b want=1", bus.busy);
    end
    wait_conv(len);
    total++;
    if (len + 1 != 6) begin
      bad++;
      $display("FAIL reset_conv_len got=%0d want=6", len + 1);
    end
    m_sel = 0;
    m_val = 0;
    capture();
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!cap_seen[d] || cap_seg[d] !== exp_seg(d, 0, 0)) begin
        bad++;
        $display("FAIL reset_digit%0d got=%b seen=%0d want=%b", d, cap_seg[d], cap_seen[d],
                 exp_seg(d, 0, 0));
      end
    end
    $display("xfer reset sel=0 val=0 digits=%b/%b/%b/%b",
             cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]);
  endtask

  task automatic test_fixed();
    test_select(1, 10);
    test_select(2, 27);
    test_select(3, 5);
  endtask

  task automatic test_random();
    int sel;
    int val;
    for (int i = 0; i < 10; i++) begin
      if ((i % 4) == 3 && m_sel >= 0) begin
        sel = m_sel;                   // same selection/value: must not retrigger
        val = m_val;
      end else begin
        sel = int'($urandom_range(0, 3));
        val = (sel == 3) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      end
      test_select(sel, val);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    int len2;
    int d_lit;
    logic [3:0] pat;
    if (m_sel == 1 && m_val == 31) test_select(0, 7);
    bus.h_select = 2'd1;
    bus.h1 = 5'd31;
    tick();                            // capture edge
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start busy=%b want=1", bus.busy);
    end
    tick();                            // second busy cycle
    bus.h1 = 5'd9;
    len = 2;
    for (int i = 0; i < 30 && bus.busy; i++) begin
      tick();
      if (bus.busy) len++;
    end
    total++;
    if (len != 6 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first_len got=%0d busy=%b want=6 busy=0", len, bus.busy);
    end
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap busy=%b want=1 after one idle cycle", bus.busy);
    end
    d_lit = -1;
    for (int d = 0; d < 4; d++) begin
      pat = 4'b0001 << d;
      if (bus.AN[3:0] == ~pat) d_lit = d;
    end
    total++;
    if (d_lit < 0 || bus.SEG !== exp_seg(d_lit, 31, 1)) begin
      bad++;
      $display("FAIL b2b_first_result digit=%0d got=%b want=%b", d_lit, bus.SEG,
               (d_lit < 0) ? 7'h00 : exp_seg(d_lit, 31, 1));
    end
    wait_conv(len2);
    total++;
    if (len2 + 1 != 6) begin
      bad++;
      $display("FAIL b2b_second_len got=%0d want=6", len2 + 1);
    end
    m_sel = 1;
    m_val = 9;
    capture();
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!cap_seen[d] || cap_seg[d] !== exp_seg(d, 9, 1)) begin
        bad++;
        $display("FAIL b2b_digit%0d got=%b seen=%0d want=%b", d, cap_seg[d], cap_seen[d],
                 exp_seg(d, 9, 1));
      end
    end
    $display("xfer b2b 31->9 first_len=%0d second_len=%0d digits=%b/%b/%b/%b", len, len2 + 1,
             cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]);
  endtask

  task automatic test_refresh();
    int cur;
    int prev;
    int run;
    int runs_done;
    int pat_bad;
    int order_bad;
    int run_bad;
    int hi_bad;
    int blank_bad;
    logic [3:0] pat;
    prev = -1; run = 0; runs_done = 0;
    pat_bad = 0; order_bad = 0; run_bad = 0; hi_bad = 0; blank_bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cur = -1;
      for (int d = 0; d < 4; d++) begin
        pat = 4'b0001 << d;
        if (bus.AN[3:0] == ~pat) cur = d;
      end
      if (cur < 0) pat_bad++;
      if (bus.AN[7:4] !== 4'hF || bus.DP !== 1'b1) hi_bad++;
      if (bus.AN[2] == 1'b0 && bus.SEG !== 7'h7F) blank_bad++;
      if (cur == prev) begin
        run++;
      end else begin
        if (prev >= 0 && cur != (prev + 1) % 4) order_bad++;
        if (prev >= 0 && runs_done > 0 && run != RD) run_bad++;
        if (prev >= 0) runs_done++;
        run = 1;
        prev = cur;
      end
    end
    total++;
    if (pat_bad != 0) begin bad++; $display("FAIL refresh_pattern bad=%0d want=0", pat_bad); end
    total++;
    if (order_bad != 0) begin bad++; $display("FAIL refresh_order bad=%0d want=0", order_bad); end
    total++;
    if (run_bad != 0 || runs_done < 8) begin
      bad++;
      $display("FAIL refresh_hold bad=%0d runs=%0d want bad=0 runs>=8", run_bad, runs_done);
    end
    total++;
    if (hi_bad != 0) begin bad++; $display("FAIL refresh_upper_dp bad=%0d want=0", hi_bad); end
    total++;
    if (blank_bad != 0) begin bad++; $display("FAIL refresh_blank2 bad=%0d want=0", blank_bad); end
    $display("xfer refresh runs=%0d", runs_done);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_back_to_back();
    test_refresh();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfg_readback_display.md
# cfg_readback_display

Readback side of the switch-driven configuration registers: continuously reads the register selected by `h_select` from the `h0`..`h3` bank and shows its value in decimal on the Nexys A7 seven-segment display, together with the register index. A sequential binary-to-BCD converter re-runs whenever the selected value or the selection changes. A free-running refresh counter multiplexes the anodes. It sits beside the register bank in the top level and drives the board `AN`/`SEG`/`DP` pins.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles each digit stays lit. Legal minimum is 2.
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `h_select`  input  2  index of the register to display (0..3).
- `h0`  input  5  config register 0.
- `h1`  input  5  config register 1.
- `h2`  input  5  config register 2.
- `h3`  input  3  config register 3, zero-extended to 5 bits internally.
- `AN`  output  8  anode enables, active-low.
- `SEG`  output  7  segments {g,f,e,d,c,b,a}, active-low.
- `DP`  output  1  decimal point, active-low, held 1.
- `busy`  output  1  high while a conversion is in progress.

## Operation
- **Mux:** `sel_val` = the selected register, 5 bits. `h3` is zero-extended.
- **Change detect:** `last_val` and `last_sel` are registered at capture time. A `valid` flag is cleared by reset.
  - In IDLE, `!valid | sel_val != last_val | h_select != last_sel` triggers a capture.
- **FSM states:** IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on trigger. Load the shift register with `sel_val`, clear the BCD accumulator, set the iteration count to 0, set `busy`.
  - SHIFT: one double-dabble iteration per cycle (add 3 to any BCD nibble >= 5, then shift left by 1). After 5 iterations, go to DONE.
  - DONE: load the display registers `ones`, `tens` and `idx` (= `last_sel`). Set `valid`, clear `busy`, return to IDLE.
- Input changes during SHIFT/DONE are ignored. They are detected on the first IDLE cycle afterwards and start a new conversion.
- Value range is 0..31, so `tens` is 0..3.
- **Digit map:**
  - AN[0] shows `ones`.
  - AN[1] shows `tens`, blanked when `tens` = 0.
  - AN[2] is always blank.
  - AN[3] shows `idx`.
  - AN[7:4] are held 1.
- **Segment codes:** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
- **Refresh:**
  - `rcnt` counts 0..REFRESH_DIV-1. On wrap, `digit` (2 bits) increments modulo 4 (3 -> 0).
  - `AN`/`SEG` are registered from `digit` and the display registers.

## Timing
- **Reset values:**
  - `AN` = 8'hFF, `SEG` = 7'h7F, `DP` = 1, `busy` = 0.
  - `ones` = `tens` = `idx` = 0, `valid` = 0, `rcnt` = 0, `digit` = 0, FSM = IDLE.
- **Conversion latency:** capture at edge E0 (`busy` = 1 after E0). SHIFT runs E1..E5. DONE is taken at E6, where the display registers update and `busy` = 0. That gives 6 cycles from capture to display.
- First conversion after reset release starts at the first edge, unconditionally (`valid` = 0).
- **Output latency:** `AN`/`SEG` reflect `digit` and the display registers one cycle later.
  - Each digit stays lit for exactly REFRESH_DIV cycles.
  - Display register updates appear on the lit digit within one cycle.
- **Reset mid-conversion:** all state returns to reset values immediately (asynchronous). The partial result is discarded.
- A selection change and a value change in the same cycle produce one conversion.

## Structure
- **Package `cfg_disp_pkg`:**
  - FSM state enum.
  - Segment constants `SEG_0`..`SEG_9`, `SEG_BLANK`.
  - `NUM_DIGITS` = 4 and `VAL_W` = 5.
- **Sub-module `bin2bcd_seq`:** sequential 5-bit double-dabble converter.
  - Ports: `start`, `bin`, `busy`, `done`, `ones`, `tens`.
  - The top level keeps the mux, change detect, display registers, refresh and segment decode.

## Test plan
All scenarios use REFRESH_DIV = 4.
1. Reset low mid-run -> `AN` = FF, `SEG` = 7F, `busy` = 0. Release with `h_select` = 0, `h0` = 0 -> `busy` high for 6 cycles, then AN[0] shows 1000000, AN[1] blank, AN[3] shows 1000000.
2. `h_select` = 1, `h1` = 10 -> AN[0] shows 1000000, AN[1] shows 1111001, AN[3] shows 1111001.
3. `h_select` = 2, `h2` = 27 -> AN[0] shows 1111000, AN[1] shows 0100100, AN[3] shows 0100100.
4. `h_select` = 3, `h3` = 5 -> AN[0] shows 0010010, AN[1] blank, AN[3] shows 0110000.
5. `h1` = 31, then change to 9 on the second busy cycle -> first result 3/1 displayed, `busy` drops for exactly one cycle, then re-asserts; final display is 9 with AN[1] blank.
6. Idle for 40 cycles ->
   - AN[3:0] cycles 1110, 1101, 1011, 0111, each held 4 cycles.
   - AN[7:4] = 1111 throughout, `DP` = 1, `SEG` = blank while AN[2] is low.
